// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory responder: issues req/ack bus accesses for loads and
// stores, stalls the pipeline while one is outstanding, and flags faults.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] Write_data_in,
    input  logic [4:0]  WriteReg_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        Stall,
    output logic [31:0] Read_data_out,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  WriteReg_out,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic        Align_fault,
    output logic        Bus_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        align_q, align_d;
    logic        timeout_q, timeout_d;

    logic op;
    logic aligned;
    logic misIdle;

    assign op      = MemRead_in | MemWrite_in;
    assign aligned = (ALUResult_in[1:0] == 2'b00);
    assign misIdle = (state_q == IDLE) & op & ~aligned;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            align_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            align_q   <= align_d;
            timeout_q <= timeout_d;
        end
    end

    // Fault flags default low so each one lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        align_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (op && aligned) begin
                    addr_d  = ALUResult_in;
                    we_d    = MemWrite_in;
                    wdata_d = Write_data_in;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end else if (op) begin
                    align_d = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d   = ERR_DATA;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // mem_req decodes straight from state so an async reset drops it at once.
    assign mem_req       = (state_q == WAIT);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign Stall         = ((state_q == IDLE) & op & aligned) | (state_q == WAIT);
    assign Read_data_out = rdata_q;
    assign Align_fault   = align_q;
    assign Bus_timeout   = timeout_q;
    assign ALUResult_out = ALUResult_in;
    assign WriteReg_out  = WriteReg_in;
    assign MemToReg_out  = MemToReg_in;
    assign RegWrite_out  = RegWrite_in & ~misIdle & ~((state_q == RESP) & timeout_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a
// transaction-level model of each memory operation.
module tb_mem_access_ctrl;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset_n;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] ALUResult_in;
    logic [31:0] Write_data_in;
    logic [4:0]  WriteReg_in;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Stall;
    logic [31:0] Read_data_out;
    logic [31:0] ALUResult_out;
    logic [4:0]  WriteReg_out;
    logic        MemToReg_out;
    logic        RegWrite_out;
    logic        Align_fault;
    logic        Bus_timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state: what the outputs must show in the current cycle, and what
    // the current cycle's events will make them show in the next one.
    logic [31:0] expRdata   = 32'd0;
    logic [31:0] nxtRdata   = 32'd0;
    logic        expAlign   = 1'b0;
    logic        nxtAlign   = 1'b0;
    logic        expTimeout = 1'b0;
    logic        nxtTimeout = 1'b0;

    logic [31:0] curAlu;
    logic [31:0] curWdata;
    logic [4:0]  curWreg;
    logic        curM2r;
    logic        curWr;

    mem_access_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .ALUResult_in  (ALUResult_in),
        .Write_data_in (Write_data_in),
        .WriteReg_in   (WriteReg_in),
        .MemToReg_in   (MemToReg_in),
        .RegWrite_in   (RegWrite_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .Stall         (Stall),
        .Read_data_out (Read_data_out),
        .ALUResult_out (ALUResult_out),
        .WriteReg_out  (WriteReg_out),
        .MemToReg_out  (MemToReg_out),
        .RegWrite_out  (RegWrite_out),
        .Align_fault   (Align_fault),
        .Bus_timeout   (Bus_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Checks one cycle at the falling edge, then advances to just past the
    // next rising edge and rolls the model forward.
    task automatic cycleCheck(input string tag, input bit expStall, input bit expReq,
                              input bit expRegWr, input bit checkBus);
        @(negedge clock);
        checkOutput({tag, ".stall"},    32'(Stall),         32'(expStall));
        checkOutput({tag, ".req"},      32'(mem_req),       32'(expReq));
        checkOutput({tag, ".regwr"},    32'(RegWrite_out),  32'(expRegWr));
        checkOutput({tag, ".alu"},      ALUResult_out,      curAlu);
        checkOutput({tag, ".wreg"},     32'(WriteReg_out),  32'(curWreg));
        checkOutput({tag, ".m2r"},      32'(MemToReg_out),  32'(curM2r));
        checkOutput({tag, ".rdata"},    Read_data_out,      expRdata);
        checkOutput({tag, ".afault"},   32'(Align_fault),   32'(expAlign));
        checkOutput({tag, ".timeout"},  32'(Bus_timeout),   32'(expTimeout));
        if (checkBus) begin
            checkOutput({tag, ".we"},    32'(mem_we), 32'(curWr));
            checkOutput({tag, ".addr"},  mem_addr,    curAlu);
            checkOutput({tag, ".wdata"}, mem_wdata,   curWdata);
        end
        @(posedge clock);
        #1;
        expRdata   = nxtRdata;
        expAlign   = nxtAlign;
        expTimeout = nxtTimeout;
        nxtAlign   = 1'b0;
        nxtTimeout = 1'b0;
    endtask

    // One instruction in EX/MEM, held until the pipeline advances past it.
    // ackDelay is the number of no-ack WAIT cycles before the ack; a value of
    // TO or more means the bus never answers.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] wreg,
                                 input bit m2r, input bit rw, input int ackDelay,
                                 input logic [31:0] ackData);
        bit timedOut;
        bit ackNow;
        MemRead_in    = rd;
        MemWrite_in   = wr;
        ALUResult_in  = addr;
        Write_data_in = wdata;
        WriteReg_in   = wreg;
        MemToReg_in   = m2r;
        RegWrite_in   = rw;
        curAlu        = addr;
        curWdata      = wdata;
        curWreg       = wreg;
        curM2r        = m2r;
        curWr         = wr;
        mem_ack       = 1'($urandom % 2);
        mem_rdata     = $urandom;
        if (!(rd || wr)) begin
            cycleCheck("nop", 1'b0, 1'b0, rw, 1'b0);
        end else if (addr[1:0] != 2'b00) begin
            nxtAlign = 1'b1;
            nxtRdata = 32'd0;
            cycleCheck("misalign", 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            cycleCheck("issue", 1'b1, 1'b0, rw, 1'b0);
            timedOut = 1'b0;
            for (int k = 0; k < int'(TO); k++) begin
                ackNow    = (k == ackDelay);
                mem_ack   = ackNow;
                mem_rdata = ackNow ? ackData : $urandom;
                if (ackNow && !wr) begin
                    nxtRdata = ackData;
                end
                if (!ackNow && k == int'(TO) - 1) begin
                    nxtRdata   = ERR;
                    nxtTimeout = 1'b1;
                    timedOut   = 1'b1;
                end
                cycleCheck("wait", 1'b1, 1'b1, rw, 1'b1);
                if (ackNow) break;
            end
            mem_ack   = 1'($urandom % 2);
            mem_rdata = $urandom;
            cycleCheck("resp", 1'b0, 1'b0, rw & ~timedOut, 1'b0);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        MemRead_in    = 1'b0;
        MemWrite_in   = 1'b0;
        ALUResult_in  = 32'd0;
        Write_data_in = 32'd0;
        WriteReg_in   = 5'd0;
        MemToReg_in   = 1'b0;
        RegWrite_in   = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;
        curAlu        = 32'd0;
        curWdata      = 32'd0;
        curWreg       = 5'd0;
        curM2r        = 1'b0;
        curWr         = 1'b0;

        #2;
        checkOutput("reset.req",     32'(mem_req),     32'd0);
        checkOutput("reset.we",      32'(mem_we),      32'd0);
        checkOutput("reset.addr",    mem_addr,         32'd0);
        checkOutput("reset.wdata",   mem_wdata,        32'd0);
        checkOutput("reset.rdata",   Read_data_out,    32'd0);
        checkOutput("reset.afault",  32'(Align_fault), 32'd0);
        checkOutput("reset.timeout", 32'(Bus_timeout), 32'd0);
        checkOutput("reset.stall",   32'(Stall),       32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b1, 0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 3, 32'h5555_AAAA);
        applyStimulus(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b1, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd7, 1'b0, 1'b1, 0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b1, 100, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_0F0F, 5'd2, 1'b0, 1'b0, 1, 32'h7777_7777);
        applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'h0, 5'd4, 1'b1, 1'b1, int'(TO) - 1, 32'h0BAD_CAFE);
        applyStimulus(1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd1, 1'b0, 1'b1, 0, 32'h0);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0);
        MemRead_in   = 1'b1;
        ALUResult_in = 32'h0000_0080;
        curAlu       = 32'h0000_0080;
        curWr        = 1'b0;
        RegWrite_in  = 1'b1;
        mem_ack      = 1'b0;
        cycleCheck("rst.issue", 1'b1, 1'b0, 1'b1, 1'b0);
        cycleCheck("rst.wait1", 1'b1, 1'b1, 1'b1, 1'b1);
        reset_n    = 1'b0;
        MemRead_in = 1'b0;
        #1;
        checkOutput("rst.req",   32'(mem_req), 32'd0);
        checkOutput("rst.stall", 32'(Stall),   32'd0);
        expRdata   = 32'd0;
        nxtRdata   = 32'd0;
        expAlign   = 1'b0;
        expTimeout = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        cycleCheck("rst.lateack", 1'b0, 1'b0, 1'b1, 1'b0);
        mem_ack = 1'b0;
        cycleCheck("rst.after", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 80; n++) begin
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            int          dly;
            rd   = 1'($urandom % 2);
            wr   = 1'($urandom % 2);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            dly  = ($urandom_range(0, 9) == 0) ? int'(TO) + 5 : int'($urandom_range(0, 5));
            applyStimulus(rd, wr, addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                          dly, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
